multiplier_share_ctrl: RTL

Two-requester round-robin controller for the shared buffered N-bit multiplier.
- Grants one requester at a time and latches its operands.
- Drives the multiplier's single operand bus with load-A then load-B strobes, waits the multiplier latency, then captures the 2N-bit product.
- Returns the product to the granted requester with a one-cycle done pulse.
- Sits between the board-level input sources (switch/UART/FSM clients) and one multiplier instance.

---
 rtl/multiplier_share_ctrl_if.sv | 36 +++
 rtl/multiplier_share_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multiplier_share_ctrl_if.sv
// Operand/result bus between the share controller and one buffered multiplier.
//
// The controller (master) time-multiplexes both operands onto mul_data.
// mul_load_a marks the cycle that carries operand A and mul_load_b marks the
// cycle that carries operand B. The multiplier (slave) returns the 2N-bit
// product on mul_result.
//
// Signals:
//   mul_data    N   controller -> multiplier, shared operand bus
//   mul_load_a  1   controller -> multiplier, operand A load strobe
//   mul_load_b  1   controller -> multiplier, operand B load strobe
//   mul_result  2N  multiplier -> controller, product
`timescale 1ns/1ps

interface multiplier_share_ctrl_if #(
    parameter int N = 8
);
    logic [N-1:0]   mul_data;
    logic           mul_load_a;
    logic           mul_load_b;
    logic [2*N-1:0] mul_result;

    modport master (
        output mul_data,
        output mul_load_a,
        output mul_load_b,
        input  mul_result
    );

    modport slave (
        input  mul_data,
        input  mul_load_a,
        input  mul_load_b,
        output mul_result
    );
endinterface

// File: rtl/multiplier_share_ctrl.sv
// Two-requester round-robin controller for one shared buffered multiplier.
//
// The controller accepts one requester at a time and latches that
// requester's operands. It loads A and then B onto the multiplier's single
// operand bus, waits MUL_LAT cycles, and captures the product. It then
// reports the product back with a one-cycle done pulse. When both
// requesters ask in the same cycle, the one that was not served last wins.
//
// Parameters:
//   N        operand width (the product is 2N bits)
//   MUL_LAT  cycles from the mul_load_b cycle until mul_result is valid (>= 1)
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   req0/a0/b0      requester 0 request level and operands
//   req1/a1/b1      requester 1 request level and operands
//   gnt0/gnt1       one-cycle pulse when a requester is accepted
//   done0/done1     one-cycle pulse when that requester's result is valid
//   result          last captured product, held until the next capture
//   busy            high whenever the controller is not idle
//   mul_bus         master side of the multiplier operand/result bus
`timescale 1ns/1ps

module multiplier_share_ctrl #(
    parameter int N       = 8,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [N-1:0]         a0,
    input  logic [N-1:0]         b0,
    input  logic                 req1,
    input  logic [N-1:0]         a1,
    input  logic [N-1:0]         b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic [2*N-1:0]       result,
    output logic                 busy,
    multiplier_share_ctrl_if.master mul_bus
);

    // The counter only has to hold MUL_LAT-1, but it is kept at least 1 bit wide.
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   result_q, result_d;

    logic             pick1;
    logic [N-1:0]     mul_data_c;
    logic             mul_load_a_c;
    logic             mul_load_b_c;

    // State register. On reset, last_q is set to 1 so that requester 0
    // wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Arbitration. Requester 1 wins if it is the only one asking, or if
    // both are asking and requester 0 was the one served last.
    always_comb begin
        pick1 = req1 && (!req0 || !last_q);
    end

    // Next-state and output decode. The bus and the strobes default to
    // zero, so mul_data is 0 in every cycle that has no load strobe.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        owner_d      = owner_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        done0        = 1'b0;
        done1        = 1'b0;
        mul_data_c   = '0;
        mul_load_a_c = 1'b0;
        mul_load_b_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d = pick1;
                    last_d  = pick1;
                    a_d     = pick1 ? a1 : a0;
                    b_d     = pick1 ? b1 : b0;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                gnt0         = !owner_q;
                gnt1         = owner_q;
                mul_data_c   = a_q;
                mul_load_a_c = 1'b1;
                state_d      = S_LOAD_B;
            end
            S_LOAD_B: begin
                mul_data_c   = b_q;
                mul_load_b_c = 1'b1;
                cnt_d        = CNT_W'(MUL_LAT - 1);
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    result_d = mul_bus.mul_result;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                done0   = !owner_q;
                done1   = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign result             = result_q;
    assign busy               = (state_q != S_IDLE);
    assign mul_bus.mul_data   = mul_data_c;
    assign mul_bus.mul_load_a = mul_load_a_c;
    assign mul_bus.mul_load_b = mul_load_b_c;

endmodule
